// File: rtl/therm_pkg.sv
// therm_pkg: shared definitions for the thermistor scan controller.
//   state_e  - sequencer states (IDLE, REQ, SETTLE, REPORT)
//   TEMP_W   - converter temperature width
//   VOLT_W   - ADC voltage code width
//   ch_idx_w - index width for n items, never less than 1
package therm_pkg;

  localparam int unsigned TEMP_W = 32;
  localparam int unsigned VOLT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SETTLE = 2'd2,
    REPORT = 2'd3
  } state_e;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/therm_period_timer.sv
// therm_period_timer: scan period counter with a one-bit pending tick.
//   clk, rst_n   - clock, async active-low reset
//   en           - scanning enable; low clears counter and pending tick
//   tick_clr     - sequencer consumed the pending tick
//   tick_pending - a scan is due
module therm_period_timer #(
  parameter int unsigned SCAN_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic tick_clr,
  output logic tick_pending
);

  localparam int unsigned CNT_W = (SCAN_PERIOD <= 2) ? 1 : $clog2(SCAN_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             en_q, en_d;

  always_comb begin
    cnt_d  = '0;
    pend_d = 1'b0;
    en_d   = en;
    if (en) begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      // A new tick wins over a same-cycle clear; ticks during a scan collapse.
      pend_d = pend_q & ~tick_clr;
      if (!en_q || (cnt_q == CNT_LAST)) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      en_q   <= en_d;
    end
  end

  assign tick_pending = pend_q;

endmodule

// File: rtl/therm_scan_ctrl.sv
// therm_scan_ctrl: time-shares one combinational thermistor converter over
// NUM_CH channels. Each period it requests an ADC sample per channel, drives
// it onto the converter, captures the temperature after CONV_LAT cycles and
// publishes one result per channel.
//   clk, rst_n          - clock, async active-low reset
//   en                  - scanning enable
//   adc_req/adc_ch      - sample request and channel
//   adc_ack/adc_data    - one-cycle ack with sample
//   conv_v/conv_temp    - converter input / output
//   res_valid/res_ch/res_temp/res_err - result pulse and payload
//   scan_done           - pulse with the last channel's result
//   busy                - sequencer not idle
// Optional build macro THERM_ALARM_EN adds temp_hi, temp_hyst inputs and a
// per-channel hysteresis alarm output.
module therm_scan_ctrl
  import therm_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned SCAN_PERIOD = 1000,
  parameter  int unsigned CONV_LAT    = 2,
  parameter  int unsigned ADC_TIMEOUT = 64,
  localparam int unsigned CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              adc_req,
  output logic [CH_W-1:0]   adc_ch,
  input  logic              adc_ack,
  input  logic [VOLT_W-1:0] adc_data,
  output logic [VOLT_W-1:0] conv_v,
  input  logic [TEMP_W-1:0] conv_temp,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [TEMP_W-1:0] res_temp,
  output logic              res_err,
  output logic              scan_done,
  output logic              busy
`ifdef THERM_ALARM_EN
  ,
  input  logic [TEMP_W-1:0] temp_hi,
  input  logic [TEMP_W-1:0] temp_hyst,
  output logic [NUM_CH-1:0] alarm
`endif
);

  localparam int unsigned CNT_MAX = (ADC_TIMEOUT > CONV_LAT) ? ADC_TIMEOUT : CONV_LAT;
  localparam int unsigned CNT_W   = ch_idx_w(CNT_MAX);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ADC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CONV_LAT - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [VOLT_W-1:0] conv_v_q, conv_v_d;
  logic [TEMP_W-1:0] res_temp_q, res_temp_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic              tick_pending;
  logic              tick_clr;

  therm_period_timer #(
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .tick_clr     (tick_clr),
    .tick_pending (tick_pending)
  );

  // One counter serves as ack timeout in REQ and settle timer in SETTLE.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    conv_v_d   = conv_v_q;
    res_temp_d = res_temp_q;
    res_ch_d   = res_ch_q;
    tick_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick_pending) begin
          tick_clr = 1'b1;
          ch_d     = '0;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Ack on the expiry cycle still counts as a good sample.
        if (adc_ack) begin
          conv_v_d = adc_data;
          cnt_d    = '0;
          state_d  = SETTLE;
        end else if (cnt_q == TMO_LAST) begin
          err_d      = 1'b1;
          res_temp_d = '0;
          res_ch_d   = ch_q;
          state_d    = REPORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == LAT_LAST) begin
          err_d      = 1'b0;
          res_temp_d = conv_temp;
          res_ch_d   = ch_q;
          state_d    = REPORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPORT: begin
        if ((ch_q == CH_LAST) || !en) begin
          state_d = IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      conv_v_q   <= '0;
      res_temp_q <= '0;
      res_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      conv_v_q   <= conv_v_d;
      res_temp_q <= res_temp_d;
      res_ch_q   <= res_ch_d;
    end
  end

  assign adc_req   = (state_q == REQ);
  assign adc_ch    = ch_q;
  assign conv_v    = conv_v_q;
  assign res_valid = (state_q == REPORT);
  assign res_ch    = res_ch_q;
  assign res_temp  = res_temp_q;
  assign res_err   = res_valid & err_q;
  assign scan_done = res_valid & (ch_q == CH_LAST);
  assign busy      = (state_q != IDLE);

`ifdef THERM_ALARM_EN
  logic [NUM_CH-1:0] alarm_q, alarm_d;
  logic [TEMP_W-1:0] clr_thr;

  // Updated on the same edge that loads res_temp, so it is visible with res_valid.
  always_comb begin
    alarm_d = alarm_q;
    clr_thr = (temp_hyst > temp_hi) ? '0 : temp_hi - temp_hyst;
    if ((state_q == SETTLE) && (cnt_q == LAT_LAST)) begin
      if (conv_temp > temp_hi) begin
        alarm_d[ch_q] = 1'b1;
      end else if (conv_temp < clr_thr) begin
        alarm_d[ch_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= '0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_therm_scan_ctrl.sv
// Directed bench for therm_scan_ctrl: conv_temp = conv_v + 100, ADC acks a
// configurable number of cycles after adc_req with data from adc_val[ch].
module tb_therm_scan_ctrl;

  localparam int unsigned NCH = 4;
  localparam int unsigned PER = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        adc_req;
  logic [1:0]  adc_ch;
  logic        adc_ack = 1'b0;
  logic [31:0] adc_data = '0;
  logic [31:0] conv_v;
  logic [31:0] conv_temp;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [31:0] res_temp;
  logic        res_err;
  logic        scan_done;
  logic        busy;
`ifdef THERM_ALARM_EN
  logic [31:0] temp_hi = 32'd150;
  logic [31:0] temp_hyst = 32'd20;
  logic [3:0]  alarm;
`endif

  therm_scan_ctrl #(
    .NUM_CH      (NCH),
    .SCAN_PERIOD (PER),
    .CONV_LAT    (LAT),
    .ADC_TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .adc_req   (adc_req),
    .adc_ch    (adc_ch),
    .adc_ack   (adc_ack),
    .adc_data  (adc_data),
    .conv_v    (conv_v),
    .conv_temp (conv_temp),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_temp  (res_temp),
    .res_err   (res_err),
    .scan_done (scan_done),
    .busy      (busy)
`ifdef THERM_ALARM_EN
    ,
    .temp_hi   (temp_hi),
    .temp_hyst (temp_hyst),
    .alarm     (alarm)
`endif
  );

  always #5 clk = ~clk;

  assign conv_temp = conv_v + 32'd100;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_rise = 0;
  logic req_prev = 1'b0;

  int          ack_dly = 3;
  int          dead_ch = -1;
  logic [31:0] adc_val [NCH];
  int          req_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (adc_req && !req_prev) req_rise = cyc;
    req_prev = adc_req;
  end

  // ADC model: ack on the ack_dly-th cycle after adc_req rises.
  always @(negedge clk) begin
    if (adc_req) begin
      if (req_cnt == ack_dly && int'(adc_ch) != dead_ch) begin
        adc_ack  = 1'b1;
        adc_data = adc_val[adc_ch];
      end else begin
        adc_ack = 1'b0;
      end
      req_cnt++;
    end else begin
      adc_ack = 1'b0;
      req_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_res(output bit ok, output int ch, output int tmp, output bit er,
                          output bit dn, output int lat, output int at);
    ok = 0; ch = 0; tmp = 0; er = 0; dn = 0; lat = 0; at = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1; ch = int'(res_ch); tmp = int'(res_temp); er = res_err;
        dn = scan_done; lat = cyc - req_rise; at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_req(input int want_ch, output bit ok, output int at);
    ok = 0; at = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (adc_req && (want_ch < 0 || int'(adc_ch) == want_ch)) begin
        ok = 1; at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, er, dn;
    int ch, tmp, lat, at, done_at, r, cnt, en_at;
    int gap [4];
    int late;

    for (int i = 0; i < NCH; i++) adc_val[i] = 32'(10 * i + 1);

    // Reset and idle with en low
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_adc_req", adc_req, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_conv_v", conv_v, 0);
    check("rst_res_temp", res_temp, 0);
    check("rst_res_ch", res_ch, 0);
    check("rst_res_err", res_err, 0);
    check("rst_scan_done", scan_done, 0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (adc_req || busy || res_valid || scan_done) cnt++;
    end
    check("idle_activity", cnt, 0);

    // Full scan starts one cycle after en is seen
    en = 1'b1;
    en_at = cyc;
    wait_req(0, ok, r);
    check("start_req_seen", ok, 1);
    check("start_delay", r - en_at, 2);
    for (int c = 0; c < 4; c++) begin
      wait_res(ok, ch, tmp, er, dn, lat, at);
      check("scan_seen", ok, 1);
      check("scan_ch", ch, c);
      check("scan_temp", tmp, 101 + 10 * c);
      check("scan_err", er, 0);
      check("scan_done", dn, (c == 3) ? 1 : 0);
      check("scan_lat", lat, 3 + LAT + 1);
    end
    @(negedge clk);
    check("scan_busy_fall", busy, 0);

    // Channel 2 never acks: timeout after 64 request cycles
    dead_ch = 2;
    for (int c = 0; c < 4; c++) begin
      wait_res(ok, ch, tmp, er, dn, lat, at);
      check("tmo_seen", ok, 1);
      check("tmo_ch", ch, c);
      check("tmo_err", er, (c == 2) ? 1 : 0);
      check("tmo_temp", tmp, (c == 2) ? 0 : 101 + 10 * c);
      check("tmo_lat", lat, (c == 2) ? TMO : 3 + LAT + 1);
      check("tmo_done", dn, (c == 3) ? 1 : 0);
    end
    dead_ch = -1;
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Overrun: slow ADC makes scans longer than the period
    ack_dly = 10;
    en = 1'b1;
    done_at = 0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        wait_res(ok, ch, tmp, er, dn, lat, at);
        check("ovr_ch", ch, c);
        check("ovr_temp", tmp, 101 + 10 * c);
      end
      check("ovr_done", dn, 1);
      done_at = at;
      if (s == 3) begin
        ack_dly = 0;
      end else begin
        wait_req(0, ok, r);
        check("ovr_gap", r - done_at, 2);
      end
    end
    // Fast ADC again: one deferred scan, then scans wait for real ticks
    for (int k = 0; k < 4; k++) begin
      wait_req(0, ok, r);
      gap[k] = r - done_at;
      for (int c = 0; c < 4; c++) wait_res(ok, ch, tmp, er, dn, lat, at);
      done_at = at;
    end
    check("defer_gap", gap[0], 2);
    late = 0;
    for (int k = 1; k < 4; k++) if (gap[k] > 2) late++;
    check("defer_single", (late > 0) ? 1 : 0, 1);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Drop en during ch1 SETTLE
    ack_dly = 3;
    en = 1'b1;
    wait_res(ok, ch, tmp, er, dn, lat, at);
    check("abort_ch0", ch, 0);
    wait_req(1, ok, r);
    cnt = 0;
    while (adc_req && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    en = 1'b0;
    wait_res(ok, ch, tmp, er, dn, lat, at);
    check("abort_ch1", ch, 1);
    check("abort_temp", tmp, 111);
    check("abort_no_done", dn, 0);
    @(negedge clk);
    check("abort_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (adc_req || res_valid) cnt++;
    end
    check("abort_quiet", cnt, 0);

    // Reset asserted during ch2 REQ
    en = 1'b1;
    wait_req(2, ok, r);
    check("rstmid_req_seen", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_req_async", adc_req, 0);
    check("rstmid_busy", busy, 0);
    cnt = 0;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    check("rstmid_no_res", cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_res_temp", res_temp, 0);
    check("rstmid_conv_v", conv_v, 0);

`ifdef THERM_ALARM_EN
    check("alarm_rst", alarm, 0);
    // ch0 results 160, 140, error, 125 against hi=150, hyst=20
    adc_val[0] = 32'd60;
    en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        wait_res(ok, ch, tmp, er, dn, lat, at);
        if (c == 0) begin
          case (s)
            0: begin check("alm_t160", tmp, 160); check("alm_set", alarm, 4'b0001); end
            1: begin check("alm_t140", tmp, 140); check("alm_hold", alarm, 4'b0001); end
            2: begin check("alm_err", er, 1); check("alm_err_hold", alarm, 4'b0001); end
            default: begin check("alm_t125", tmp, 125); check("alm_clr", alarm, 4'b0000); end
          endcase
        end
      end
      if (s == 0) adc_val[0] = 32'd40;
      if (s == 1) dead_ch = 0;
      if (s == 2) begin dead_ch = -1; adc_val[0] = 32'd25; end
    end
    check("alm_final", alarm, 4'b0000);
    en = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
